// File: rtl/pwl_pkg.sv
// Shared constants and helpers for the piecewise-linear lane evaluator.
// The saturate and slice helpers take widths as arguments so any instance width can use them.
package pwl_pkg;

    localparam int unsigned PWL_DW       = 16;
    localparam int unsigned PWL_FRAC     = 12;
    localparam int unsigned PWL_KW       = 16;
    localparam int unsigned PWL_SEG_BITS = 4;

    // Identity segment entry: y = 1.0 * x + 0.
    localparam logic signed [PWL_KW-1:0] PWL_IDENTITY_K = PWL_KW'(1 << PWL_FRAC);
    localparam logic signed [PWL_KW-1:0] PWL_IDENTITY_B = '0;

    function automatic logic [63:0] ident_k(input int unsigned frac);
        return 64'd1 << frac;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
        return lane * dw;
    endfunction

    // Clip v to the signed dw-bit range; clipped reports whether a bound was applied.
    function automatic logic signed [63:0] sat_clip(input  logic signed [63:0] v,
                                                    input  int unsigned        dw,
                                                    output logic               clipped);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi      = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (dw - 1));
        res     = v;
        clipped = 1'b0;
        if (v > hi) begin
            res     = hi;
            clipped = 1'b1;
        end else if (v < lo) begin
            res     = lo;
            clipped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwl_lanes_if.sv
// Stream handshake bundle for pwl_lanes: input beats in, per-lane results and clip flags out.
interface pwl_lanes_if #(
    parameter int unsigned LANES = 10,
    parameter int unsigned DW    = 16
) ();
    logic                s_valid;
    logic                s_ready;
    logic [LANES*DW-1:0] s_data;
    logic                m_valid;
    logic                m_ready;
    logic [LANES*DW-1:0] m_data;
    logic [LANES-1:0]    m_sat;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sat
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sat
    );
endinterface

// File: rtl/pwl_lane.sv
// One lane of the S2/S3 datapath: registered x*k, then round, add intercept and saturate.
module pwl_lane
    import pwl_pkg::*;
#(
    parameter int unsigned DW   = PWL_DW,
    parameter int unsigned FRAC = PWL_FRAC,
    parameter int unsigned KW   = PWL_KW
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [KW-1:0] i_k,
    input  logic signed [KW-1:0] i_b,
    output logic [DW-1:0]        o_y,
    output logic                 o_sat
);
    localparam int unsigned PW = DW + KW;
    localparam int unsigned SW = DW + KW + 1;
    localparam logic signed [SW-1:0] ROUND = SW'(1) <<< (FRAC - 1);

    logic signed [PW-1:0] r_p;
    logic signed [KW-1:0] r_b;
    logic signed [SW-1:0] w_s;
    logic [DW-1:0]        w_y;
    logic                 w_sat;
    logic [DW-1:0]        r_y;
    logic                 r_sat;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_p <= '0;
            r_b <= '0;
        end else if (i_en) begin
            r_p <= PW'(i_x) * PW'(i_k);
            r_b <= i_b;
        end
    end

    // Round half up, then add the sign-extended intercept in a width that cannot overflow.
    always_comb begin
        w_sat = 1'b0;
        w_s   = ((SW'(r_p) + ROUND) >>> FRAC) + SW'(r_b);
        w_y   = DW'(sat_clip(64'(w_s), DW, w_sat));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_y   <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_y   <= w_y;
            r_sat <= w_sat;
        end
    end

    assign o_y   = r_y;
    assign o_sat = r_sat;

endmodule

// File: rtl/pwl_lanes.sv
// LANES-wide piecewise-linear evaluator y = k[seg(x)]*x + b[seg(x)] with a writable segment
// table, a 3-stage lock-step pipeline and valid/ready handshaking on both sides.
module pwl_lanes
    import pwl_pkg::*;
#(
    parameter int unsigned LANES    = 10,
    parameter int unsigned DW       = PWL_DW,
    parameter int unsigned FRAC     = PWL_FRAC,
    parameter int unsigned KW       = PWL_KW,
    parameter int unsigned SEG_BITS = PWL_SEG_BITS
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    pwl_lanes_if.slave           bus,
    input  logic                 cfg_we,
    input  logic [SEG_BITS-1:0]  cfg_addr,
    input  logic signed [KW-1:0] cfg_k,
    input  logic signed [KW-1:0] cfg_b
);
    localparam int unsigned DEPTH = 2 ** SEG_BITS;
    localparam logic signed [KW-1:0] ID_K = KW'(ident_k(FRAC));

    logic signed [KW-1:0] r_tab_k [DEPTH];
    logic signed [KW-1:0] r_tab_b [DEPTH];
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_v3;
    logic                 w_en;
    logic [LANES*DW-1:0]  w_m_data;
    logic [LANES-1:0]     w_m_sat;

    // All stages move together; the only stall source is a held output beat.
    assign w_en        = !r_v3 || bus.m_ready;
    assign bus.s_ready = w_en;
    assign bus.m_valid = r_v3;
    assign bus.m_data  = w_m_data;
    assign bus.m_sat   = w_m_sat;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_tab_k[i] <= ID_K;
                r_tab_b[i] <= '0;
            end
        end else if (cfg_we) begin
            r_tab_k[cfg_addr] <= cfg_k;
            r_tab_b[cfg_addr] <= cfg_b;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= bus.s_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DW-1:0] w_x;
        logic [SEG_BITS-1:0]  w_seg;
        logic signed [DW-1:0] r_x;
        logic signed [KW-1:0] r_k;
        logic signed [KW-1:0] r_b;

        assign w_x   = bus.s_data[lane_lsb(g, DW) +: DW];
        assign w_seg = w_x[DW-1 -: SEG_BITS];

        // Lookup at capture: a table write on the same edge is not seen by this beat.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_x <= '0;
                r_k <= '0;
                r_b <= '0;
            end else if (w_en) begin
                r_x <= w_x;
                r_k <= r_tab_k[w_seg];
                r_b <= r_tab_b[w_seg];
            end
        end

        pwl_lane #(
            .DW   (DW),
            .FRAC (FRAC),
            .KW   (KW)
        ) u_lane (
            .aclk    (aclk),
            .aresetn (aresetn),
            .i_en    (w_en),
            .i_x     (r_x),
            .i_k     (r_k),
            .i_b     (r_b),
            .o_y     (w_m_data[lane_lsb(g, DW) +: DW]),
            .o_sat   (w_m_sat[g])
        );
    end

endmodule

// File: tb/tb_pwl_lanes.sv
// Self-checking bench for pwl_lanes: directed scenarios plus randomized traffic scored against
// an arithmetic reference model of the segment table and the y = k*x + b rule.
module tb_pwl_lanes;
    localparam int unsigned LANES    = 10;
    localparam int unsigned DW       = 16;
    localparam int unsigned FRAC     = 12;
    localparam int unsigned KW       = 16;
    localparam int unsigned SEG_BITS = 4;
    localparam int unsigned W        = LANES * DW;
    localparam int unsigned DEPTH    = 2 ** SEG_BITS;
    localparam longint      YMAX     = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint      YMIN     = -(longint'(1) <<< (DW - 1));

    typedef struct packed {
        logic [W-1:0]     d;
        logic [LANES-1:0] s;
    } beat_t;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b1;
    logic                cfg_we;
    logic [SEG_BITS-1:0] cfg_addr;
    logic [KW-1:0]       cfg_k;
    logic [KW-1:0]       cfg_b;

    pwl_lanes_if #(.LANES(LANES), .DW(DW)) bus ();

    pwl_lanes #(
        .LANES    (LANES),
        .DW       (DW),
        .FRAC     (FRAC),
        .KW       (KW),
        .SEG_BITS (SEG_BITS)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .bus      (bus),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_k    (cfg_k),
        .cfg_b    (cfg_b)
    );

    always #5 aclk = ~aclk;

    int    n_vec = 0;
    int    n_miss = 0;
    int    tk [DEPTH];
    int    tbv [DEPTH];
    beat_t expq [$];
    bit    rand_ready = 1'b0;
    logic  last_acc = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            tk[i]  = 1 << FRAC;
            tbv[i] = 0;
        end
    endfunction

    // y = clip(round(x*k / 2**FRAC) + b) per lane, with k,b chosen by the top bits of x.
    function automatic beat_t model(input logic [W-1:0] d);
        beat_t e;
        e = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            longint x;
            longint p;
            longint r;
            longint s;
            int     seg;
            x   = longint'($signed(d[i*DW +: DW]));
            seg = int'(d[i*DW + DW - 1 -: SEG_BITS]);
            p   = x * longint'(tk[seg]);
            r   = (p + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
            s   = r + longint'(tbv[seg]);
            if (s > YMAX) begin
                s = YMAX;
                e.s[i] = 1'b1;
            end else if (s < YMIN) begin
                s = YMIN;
                e.s[i] = 1'b1;
            end
            e.d[i*DW +: DW] = DW'(s);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] fill(input int v);
        logic [DW-1:0] l;
        l = DW'(v);
        return {LANES{l}};
    endfunction

    // One clock: called at edge+1 with inputs set; scores handshakes and stall stability.
    task automatic cycle();
        logic         emit;
        logic         stalled;
        logic [W-1:0] pd;
        logic [W-1:0] ps;
        beat_t        e;
        if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
        #1;
        chk("s_ready_rule", W'(bus.s_ready), W'(!(bus.m_valid && !bus.m_ready)));
        last_acc = bus.s_valid && bus.s_ready;
        emit     = bus.m_valid && bus.m_ready;
        stalled  = bus.m_valid && !bus.m_ready;
        pd       = bus.m_data;
        ps       = W'(bus.m_sat);
        chk("no_spurious_beat", W'(emit && (expq.size() == 0)), W'(0));
        if (emit && expq.size() != 0) begin
            e = expq.pop_front();
            chk("m_data", bus.m_data, e.d);
            chk("m_sat", W'(bus.m_sat), W'(e.s));
        end
        if (last_acc) expq.push_back(model(bus.s_data));
        if (cfg_we && aresetn) begin
            tk[cfg_addr]  = int'($signed(cfg_k));
            tbv[cfg_addr] = int'($signed(cfg_b));
        end
        @(posedge aclk);
        #1;
        cfg_we = 1'b0;
        if (stalled) begin
            chk("hold_valid", W'(bus.m_valid), W'(1));
            chk("hold_data", bus.m_data, pd);
            chk("hold_sat", W'(bus.m_sat), ps);
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        int n;
        n           = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        last_acc    = 1'b0;
        while (!last_acc && n < 64) begin
            cycle();
            n++;
        end
        bus.s_valid = 1'b0;
        chk("send_accept", W'(last_acc), W'(1));
    endtask

    task automatic drain(input int budget);
        int n;
        n           = 0;
        bus.s_valid = 1'b0;
        while (expq.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", W'(expq.size()), W'(0));
    endtask

    task automatic write_cfg(input int addr, input int k, input int b);
        cfg_we   = 1'b1;
        cfg_addr = SEG_BITS'(addr);
        cfg_k    = KW'(k);
        cfg_b    = KW'(b);
    endtask

    task automatic latency_check(input string tag);
        chk({tag, "_lat1"}, W'(bus.m_valid), W'(0));
        cycle();
        chk({tag, "_lat2"}, W'(bus.m_valid), W'(0));
        cycle();
        chk({tag, "_lat3"}, W'(bus.m_valid), W'(1));
    endtask

    initial begin
        logic [W-1:0] d;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_k       = '0;
        cfg_b       = '0;
        model_reset();

        // Reset state
        #1 aresetn = 1'b0;
        #1;
        chk("rst_m_valid", W'(bus.m_valid), W'(0));
        chk("rst_m_data", bus.m_data, W'(0));
        chk("rst_m_sat", W'(bus.m_sat), W'(0));
        chk("rst_s_ready", W'(bus.s_ready), W'(1));
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;

        // Identity table after reset, with exact 3-cycle latency
        d = '0;
        d[0*DW +: DW] = 16'h1000;
        d[1*DW +: DW] = 16'hF000;
        send(d);
        latency_check("ident");
        drain(20);

        // Table write on the capture edge: that beat sees the old entry, the next the new one
        write_cfg(1, 'h3000, 0);
        send(fill('h1000));
        send(fill('h1000));
        drain(20);

        // Programmed segment with intercept
        write_cfg(1, 'h2000, 'h0800);
        cycle();
        send(fill('h1000));
        send(fill('h1800));
        drain(20);

        // Saturation at both bounds; zero lanes stay unclipped
        write_cfg(7, 'h2000, 0);
        cycle();
        write_cfg(8, 'h2000, 0);
        cycle();
        d = '0;
        d[0*DW +: DW] = 16'h7000;
        d[1*DW +: DW] = 16'h8000;
        d[5*DW +: DW] = 16'h7FFF;
        send(d);
        drain(20);

        // Backpressure: ordered beats under random m_ready
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(fill(i));
        drain(400);

        // Randomized traffic with interleaved table writes
        for (int c = 0; c < 300; c++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'(LANES); i++) d[i*DW +: DW] = DW'($urandom);
            bus.s_data = d;
            if ($urandom_range(0, 7) == 0) begin
                write_cfg(int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, 32'h6000)) - 'h3000,
                          int'($urandom_range(0, 32'h2000)) - 'h1000);
            end
            cycle();
        end
        drain(600);
        rand_ready  = 1'b0;
        bus.m_ready = 1'b1;

        // Reset with three beats in flight
        send(fill('h0100));
        send(fill('h0200));
        send(fill('h0300));
        #2 aresetn = 1'b0;
        #1;
        chk("midrst_m_valid", W'(bus.m_valid), W'(0));
        chk("midrst_m_data", bus.m_data, W'(0));
        chk("midrst_m_sat", W'(bus.m_sat), W'(0));
        expq.delete();
        model_reset();
        @(posedge aclk);
        #1;
        cycle();
        cycle();
        aresetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("no_stale_beat", W'(bus.m_valid), W'(0));
        end
        send(fill('h1000));
        latency_check("post_rst");
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwl_lanes.md
Name: pwl_lanes

Overview:
- Parametrised, LANES-wide, fixed-point piecewise-linear evaluator: y = k[seg(x)]*x + b[seg(x)].
- Coefficients come from an internal runtime-writable segment table; they are not fed as per-lane ports.
- Sits in the SoftMax datapath in front of the normalisation stage and supplies exp() and reciprocal approximations.
- Fully pipelined with valid/ready handshaking on both sides and per-lane saturation flags.

Parameters:
LANES, 10, number of parallel lanes
DW, 16, width of x and y (signed two's complement)
FRAC, 12, fractional bits of x, y, k and b (Q3.12 at default)
KW, 16, width of k and b table entries (signed)
SEG_BITS, 4, index bits; table depth = 2**SEG_BITS

Ports:
aclk  in  1  clock; all logic is rising-edge
aresetn  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_data  in  LANES*DW  lane i = s_data[i*DW +: DW]
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts
m_data  out  LANES*DW  lane i result
m_sat  out  LANES  lane i result was clipped
cfg_we  in  1  table write strobe
cfg_addr  in  SEG_BITS  table entry to write
cfg_k  in  KW  slope
cfg_b  in  KW  intercept

Behaviour:
- Reset (async assert, sync release):
  - All pipeline valid bits clear; m_valid=0, m_data=0, m_sat=0.
  - Every table entry is set to k=1<<FRAC, b=0 (identity).
  - In-flight data is discarded.
- Segment index: seg = x[DW-1 -: SEG_BITS], the raw top bits, so segments follow two's-complement order (0x0..0x7 non-negative, 0x8..0xF negative).
- Pipeline: 3 stages, with latency of exactly 3 cycles from acceptance to m_valid when unstalled.
  - S1 registers x and looks up k,b for each lane; all lanes share one table with LANES read ports.
  - S2 computes and registers the signed product p = x*k, width DW+KW.
  - S3 computes r = (p + (1<<(FRAC-1))) >>> FRAC, i.e. round-half-up arithmetic shift. It then computes s = r + sign-extended b, width DW+KW+1, and saturates s to the signed DW range.
  - S3 registers m_data and sets m_sat=1 when clipped.
- Flow control:
  - en = !m_valid || m_ready. All stages advance together when en=1; s_ready = en, combinational from m_valid/m_ready only.
  - A stage with valid=0 still shifts.
  - When en=0, every stage, m_data and m_sat hold stable; m_data must not change while m_valid&&!m_ready.
- Throughput: 1 beat/cycle with m_ready held high. No beat is dropped or duplicated under any m_ready pattern.
- Table write:
  - The write commits on the clock edge where cfg_we=1, independent of en.
  - A beat captured into S1 on that same edge uses the old entry. Beats captured on later edges use the new entry.
  - A beat already past S1 is unaffected.
- Saturation bounds: max 2**(DW-1)-1, min -2**(DW-1). The m_sat bit for a lane is per beat and per lane.
- Reset mid-operation: outputs drop to reset values asynchronously. After release, the first output appears 3 cycles after the first accepted beat.

Decomposition:
- Package pwl_pkg holds:
  - default DW/FRAC/KW/SEG_BITS constants
  - the identity-entry constant (1<<FRAC, 0)
  - a saturate function (width-generic via parameters at call site)
  - the lane slice helper
- Sub-module pwl_lane holds the S2/S3 multiply, round, add and saturate datapath for one lane. It takes en, x, k, b and produces y and sat, and is instantiated LANES times.
- The top holds the table, S1 registers, valid pipeline and handshake.

Test Plan:
- Identity after reset: lane0 x=0x1000, lane1 x=0xF000, others 0, m_ready=1 -> 3 cycles later m_data lane0=0x1000, lane1=0xF000, m_sat=0.
- Programmed segment: write addr=1 k=0x2000 b=0x0800, then x=0x1000 on all lanes -> every lane 0x2800. Also x=0x1800 -> 0x3800.
- Saturation: write addr=7 k=0x2000 b=0, x=0x7000 -> y=0x7FFF, sat=1. Write addr=8 k=0x2000, x=0x8000 -> y=0x8000, sat=1. Other lanes with x=0 -> sat=0.
- Backpressure: stream 8 beats with x=beat index, m_ready toggled on a pseudo-random pattern. The bench checks:
  - outputs arrive in order, with none lost or duplicated;
  - m_data stays stable while stalled;
  - s_ready=0 exactly when m_valid&&!m_ready.
- Write/capture race: cfg_we for addr=1 (k=0x3000) on the same edge a beat x=0x1000 is accepted -> that beat yields 0x1000 (old identity). The next beat x=0x1000 yields 0x3000.
- Reset mid-stream: assert aresetn low with 3 beats in flight -> m_valid=0 immediately. After release, no stale beats are emitted and the table is back to identity (x=0x1000 -> 0x1000).
